// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: NUM_CH servo PWM outputs on a shared FRAME_US timebase, commands double-buffered to frame boundaries.
// Optional macro SLEW_LIMIT_EN: active commands step toward shadow by at most SLEW_STEP per frame.
module servo_pwm_multi #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int NUM_CH    = 4,
  parameter int DUTY_W    = 8,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int FRAME_US  = 20000,
  parameter int SLEW_STEP = 4,
  localparam int CH_W     = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [DUTY_W-1:0] wr_duty_i,
  output logic [NUM_CH-1:0] pwm_out_o,
  output logic              frame_start_o
);
  localparam int PRE  = CLK_HZ / 1_000_000;
  localparam int PW   = PRE > 1 ? $clog2(PRE) : 1;
  localparam int UW   = $clog2(FRAME_US);
  localparam int WW   = $clog2(MAX_US + 1);
  localparam int DMAX = (1 << DUTY_W) - 1;
  localparam logic [DUTY_W-1:0] CENTRE = DUTY_W'(1 << (DUTY_W - 1));
  localparam logic [WW-1:0] CENTRE_W = WW'(MIN_US + (1 << (DUTY_W - 1)) * (MAX_US - MIN_US) / DMAX);

  logic [PW-1:0]     pre_q, pre_d;
  logic [UW-1:0]     us_q, us_d;
  logic              us_tick, boundary, wr_ok;
  logic              enable_q, frame_start_q;
  logic [DUTY_W-1:0] shadow_q [NUM_CH];
  logic [DUTY_W-1:0] active_q [NUM_CH];
  logic [DUTY_W-1:0] active_d [NUM_CH];
  logic [WW-1:0]     width_q [NUM_CH];
  logic [WW-1:0]     width_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;

`ifdef SLEW_LIMIT_EN
  function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] a, input logic [DUTY_W-1:0] s);
    logic [DUTY_W-1:0] st;
    st = DUTY_W'(SLEW_STEP);
    return s > a ? ((s - a) > st ? a + st : s) : ((a - s) > st ? a - st : s);
  endfunction
`endif

  always_comb begin
    us_tick  = pre_q == PW'(PRE - 1);
    boundary = us_tick && us_q == UW'(FRAME_US - 1);
    pre_d    = us_tick ? '0 : pre_q + PW'(1);
    us_d     = boundary ? '0 : us_tick ? us_q + UW'(1) : us_q;
    wr_ok    = wr_en_i && 32'(wr_ch_i) < NUM_CH;
  end

  // width lags active by one clk; pulses start at us_cnt=0 where any width >= MIN_US > 0 holds
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef SLEW_LIMIT_EN
      active_d[i] = slew(active_q[i], shadow_q[i]);
`else
      active_d[i] = shadow_q[i];
`endif
      width_d[i] = WW'(MIN_US + 32'(active_q[i]) * (MAX_US - MIN_US) / DMAX);
      pwm_d[i]   = enable_q && (32'(us_q) < 32'(width_q[i]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q         <= '0;
      us_q          <= '0;
      enable_q      <= 1'b0;
      frame_start_q <= 1'b0;
      pwm_q         <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= CENTRE;
        active_q[i] <= CENTRE;
        width_q[i]  <= CENTRE_W;
      end
    end else begin
      pre_q         <= pre_d;
      us_q          <= us_d;
      frame_start_q <= boundary;
      pwm_q         <= pwm_d;
      if (boundary) enable_q <= enable_i;
      for (int i = 0; i < NUM_CH; i++) begin
        if (boundary) active_q[i] <= active_d[i];
        width_q[i] <= width_d[i];
        if (wr_ok && 32'(wr_ch_i) == i) shadow_q[i] <= wr_duty_i;
      end
    end
  end

  assign pwm_out_o     = pwm_q;
  assign frame_start_o = frame_start_q;
endmodule
